// File: rtl/cpu_ram_arbiter.sv
// rtl/cpu_ram_arbiter.sv - CPU/bridge arbiter for the 2 KB main-CPU work RAM
// Define CPU_RAM_CLEAR_EN to zero-fill the RAM after every reset.
module cpu_ram_arbiter #(
  parameter int BR_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_wait,
  output logic        cpu_valid,
  output logic [7:0]  cpu_dout,
  input  logic        br_req,
  input  logic        br_we,
  input  logic [10:0] br_addr,
  input  logic [7:0]  br_din,
  output logic        br_ack,
  output logic [7:0]  br_dout,
  output logic [10:0] ram_address,
  output logic        ram_write,
  output logic [7:0]  ram_data,
  input  logic [7:0]  ram_q,
  output logic        busy
);

  typedef enum logic [2:0] {CLEAR, IDLE, BR_WAIT, BR_ACK, BR_DROP} state_t;

`ifdef CPU_RAM_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [10:0] clr_addr;
  logic        cpu_grant, br_grant;
  logic        cpu_rd_p1, br_p1, br_rd_p1;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    cpu_grant    = 1'b0;
    br_grant     = 1'b0;
    ram_address  = '0;
    ram_write    = 1'b0;
    ram_data     = '0;
    // Reset forces the RAM lines idle even though the state already reads CLEAR.
    if (reset_n) begin
      case (state)
        CLEAR: begin
          ram_write   = 1'b1;
          ram_address = clr_addr;
          if (clr_addr == 11'h7FF) state_nxt = IDLE;
        end
        IDLE: begin
          if (br_req && (!cpu_req || wait_cnt == 4'(BR_MAX_WAIT))) begin
            br_grant     = 1'b1;
            wait_cnt_nxt = '0;
            state_nxt    = BR_WAIT;
          end else if (cpu_req) begin
            cpu_grant = 1'b1;
            if (br_req) wait_cnt_nxt = wait_cnt + 4'd1;
          end
        end
        BR_WAIT: begin
          cpu_grant = cpu_req;
          state_nxt = BR_ACK;
        end
        BR_ACK: begin
          cpu_grant = cpu_req;
          state_nxt = BR_DROP;
        end
        BR_DROP: begin
          cpu_grant = cpu_req;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
      if (br_grant) begin
        ram_address = br_addr;
        ram_write   = br_we;
        ram_data    = br_din;
      end else if (cpu_grant) begin
        ram_address = cpu_addr;
        ram_write   = cpu_we;
        ram_data    = cpu_din;
      end
    end
    cpu_wait = cpu_req & ~cpu_grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_STATE;
      wait_cnt  <= '0;
      cpu_rd_p1 <= 1'b0;
      br_p1     <= 1'b0;
      br_rd_p1  <= 1'b0;
      cpu_valid <= 1'b0;
      cpu_dout  <= '0;
      br_ack    <= 1'b0;
      br_dout   <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      cpu_rd_p1 <= cpu_grant & ~cpu_we;
      br_p1     <= br_grant;
      br_rd_p1  <= br_grant & ~br_we;
      cpu_valid <= cpu_rd_p1;
      br_ack    <= br_p1;
      if (cpu_rd_p1) cpu_dout <= ram_q;
      if (br_rd_p1)  br_dout  <= ram_q;
    end
  end

`ifdef CPU_RAM_CLEAR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      clr_addr <= '0;
    else if (state == CLEAR && clr_addr != 11'h7FF)
      clr_addr <= clr_addr + 11'd1;
  end
  assign busy = (state == CLEAR);
`else
  assign clr_addr = '0;
  assign busy     = 1'b0;
`endif

endmodule

// File: doc/cpu_ram_arbiter.md
# cpu_ram_arbiter

Shares the 2 KB single-port main-CPU work RAM (11-bit address, 8-bit data, registered read, read-before-write) between the main 6809 bus and the APF bridge port used for high-score save/load. It sits between both requesters and the RAM macro and drives the RAM's address, write and data lines. CPU accesses get priority, with bounded bridge starvation. An optional engine zero-fills the RAM after reset.

## Interface
Parameters:
- BR_MAX_WAIT, 4: consecutive bridge-blocked cycles after which the bridge wins the next contested cycle (1..15).

Ports:
- clk  in  1  core clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request for this cycle; held while cpu_wait=1
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  11  CPU word address
- cpu_din  in  8  CPU write data
- cpu_wait  out  1  combinational; request not granted this cycle
- cpu_valid  out  1  one-cycle pulse; cpu_dout holds read data
- cpu_dout  out  8  registered CPU read data
- br_req  in  1  bridge request; level, held until br_ack
- br_we  in  1  bridge write enable
- br_addr  in  11  bridge address
- br_din  in  8  bridge write data
- br_ack  out  1  one-cycle completion pulse
- br_dout  out  8  registered bridge read data, valid with br_ack
- ram_address  out  11  to RAM address
- ram_write  out  1  to RAM write
- ram_data  out  8  to RAM data
- ram_q  in  8  RAM registered read data
- busy  out  1  clear engine active

## Operation
- FSM states: CLEAR, IDLE, BR_WAIT, BR_ACK, BR_DROP.
- RAM drive is combinational from the current cycle's grant. With no grant: ram_write=0, ram_address=0, ram_data=0.
- IDLE, cpu_req only: CPU granted; ram_* = cpu_*.
- IDLE, br_req only: bridge granted; FSM moves to BR_WAIT.
- IDLE, both requesting: CPU wins and cpu_wait=0. Bridge wait counter (4 bits) increments.
- Counter == BR_MAX_WAIT: bridge wins instead. cpu_wait=1 that cycle and the counter clears.
- Counter clears on every bridge grant.
- BR_WAIT → BR_ACK → BR_DROP → IDLE, unconditionally.
- During these three states br_req is ignored, but CPU requests are granted normally.
- BR_DROP gives the bridge one cycle to deassert br_req.
- Reads: ram_q is captured at the end of grant+1 into cpu_dout or br_dout.
- Writes: the completion pulse still fires, and the dout register is not updated. cpu_valid pulses for reads only; br_ack pulses for both reads and writes.
- CLEAR: an 11-bit counter walks addresses 0..2047 with ram_write=1 and ram_data=0x00, one address per cycle.
  - busy=1 throughout; cpu_wait=cpu_req; the bridge is not granted.
  - After address 2047 is written, the FSM goes to IDLE.

## Timing
- Grant cycle G: the RAM samples at the end of G. Read data is on ram_q during G+1. cpu_valid/br_ack plus data are high during G+2.
- Read latency is 2 cycles from grant. CPU back-to-back accesses run at one per cycle, pipelined.
- Reset values (held while reset_n=0):
  - cpu_valid, cpu_dout, br_ack, br_dout, ram_write, ram_address, ram_data all 0.
  - cpu_wait=cpu_req.
  - busy=1 if CLEAR is compiled in, else 0.
  - FSM state CLEAR or IDLE; counters 0.
- Reset mid-access: the pending ack/valid is dropped, not delivered. Mid-clear: the clear restarts at address 0.
- Address wrap: none; addresses are used as given. Clear stops at 2047 and does not wrap.

## Configuration
- CPU_RAM_CLEAR_EN defined: the CLEAR state and its counter are present. Reset enters CLEAR, giving 2048 cycles of zero-fill with busy=1.
- Not defined: reset enters IDLE directly, busy is tied to 0, and the RAM keeps its contents across reset.

## Test plan
- Clear: release reset with CPU_RAM_CLEAR_EN -> busy=1 for exactly 2048 cycles, ram_write=1 for addresses 0..2047, data 0x00. A CPU read of 0x7FF afterwards returns 0x00.
- CPU path: write 0xA5 to 0x123, then read 0x123 on the next cycle -> cpu_valid two cycles after the read grant, cpu_dout=0xA5, cpu_wait=0 throughout.
- Bridge path: br_req write 0x3C to 0x010, then read 0x010 -> br_ack 2 cycles after each grant, br_dout=0x3C, no re-grant during BR_DROP.
- Starvation: cpu_req held continuously plus br_req with BR_MAX_WAIT=4 -> bridge granted on the 5th contested cycle with cpu_wait=1 for that single cycle.
- Reset: assert reset_n=0 during BR_WAIT -> no br_ack ever. All outputs return to reset values within the same cycle, and clear restarts at 0.
